cordic_seq: RTL and testbench
=============================

CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 The block SHALL have parameter n, default 32, which sets the datapath width in bits (two's complement).
REQ-002 The block SHALL have parameter frac, default 16, which sets the number of fractional bits of x, y and z.
REQ-003 The block SHALL have parameter iter, default 16, which sets the number of CORDIC iterations; legal range 1..16.
REQ-004 Port clk_i: input, width 1, single clock; all state changes on the rising edge.
REQ-005 Port rst_ni: input, width 1, reset that is asynchronous and active-low.
REQ-006 Port start_i: input, width 1, start request, sampled on the rising edge.
REQ-007 Port x_i, y_i, z_i: input, width n each, initial vector and angle in radians.
REQ-008 Port busy_o: output, width 1, high while iterating.
REQ-009 Port done_o: output, width 1, one-cycle result-valid pulse.
REQ-010 Port x_o, y_o, z_o: output, width n each, registered results.
REQ-011 Port iter_o: output, width 4, current iteration index (shift amount).

Function
REQ-012 Rotation mode: per iteration i, with d = +1 if z[n-1]==0 else -1:
- x <= x - d*(y >>> i)
- y <= y + d*(x >>> i)
- z <= z - d*atan_lut[i]
REQ-013 Both shifts SHALL be sign-extending arithmetic right shifts by i, from two shift_reg instances (width n) whose addr_i is driven by the iteration counter.
REQ-014 atan_lut[i] SHALL be the constant round(atan(2^-i) * 2^frac), indexed 0..iter-1, with n bits.
REQ-015 Add and subtract SHALL be n-bit with two's-complement wrap-around, no saturation; no gain compensation (caller pre-scales by K = 0.607253).
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE with start_i=1 SHALL load x, y and z from the inputs, clear the counter to 0, and go to RUN.
REQ-018 RUN SHALL perform one iteration per clock and increment the counter.
REQ-019 After the iteration with counter == iter-1, the FSM SHALL go to DONE.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-021 If start_i=1 in DONE, the FSM SHALL load the new inputs and go directly to RUN (back-to-back operation).
REQ-022 busy_o SHALL equal (state == RUN).
REQ-023 done_o SHALL equal (state == DONE).
REQ-024 Latency: with start sampled at edge k, iterations occur on edges k+1..k+iter, and done_o is high in the cycle after edge k+iter.
REQ-025 With iter=16, done_o SHALL be high in the cycle after edge k+16.
REQ-026 start_i SHALL be ignored while in RUN, with no reload and no restart.
REQ-027 x_o, y_o and z_o SHALL be the working registers.
REQ-028 x_o, y_o and z_o are valid while done_o=1 and SHALL hold until the next accepted start.
REQ-029 iter_o SHALL show the counter value and SHALL be 0 outside RUN.
REQ-030 The counter SHALL never exceed iter-1.

Reset
REQ-031 On rst_ni=0, asynchronously: state=IDLE, counter=0, x/y/z=0, busy_o=0, done_o=0, iter_o=0.
REQ-032 Reset asserted during RUN SHALL abort the operation with no done_o pulse.
REQ-033 After reset release, the block SHALL accept start_i on the first rising edge.

Verification
REQ-034 x_i=0x00009B75, y_i=0, z_i=0, start pulse -> done_o exactly 17 cycles after the start edge; x_o=0x00010000 ±8 LSB; y_o=0 ±8 LSB; z_o near 0.
REQ-035 x_i=0x00009B75, y_i=0, z_i=0x0000C910 (pi/4) -> x_o and y_o = 0x0000B505 ±8 LSB.
REQ-036 Same vector as REQ-035 with z_i=0xFFFF36F0 (-pi/4) -> x_o=0x0000B505 ±8; y_o=0xFFFF4AFB ±8.
REQ-037 start_i held high for 40 cycles -> done_o pulses every 17 cycles; busy_o low only in DONE cycles; start_i ignored during RUN.
REQ-038 rst_ni pulsed low at iteration 7 -> all outputs 0 immediately; no done_o; next start yields correct REQ-034 results.
REQ-039 iter_o check on a run -> iter_o sequences 0,1,...,15 during RUN, then 0.

Source files
------------

// File: rtl/cordic_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, no gain compensation.
// The caller pre-scales the input vector by K = 0.607253.

module shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] data_i,
  input  logic        [3:0]       addr_i,
  output logic signed [WIDTH-1:0] data_o
);
  assign data_o = data_i >>> addr_i;
endmodule

module cordic_seq #(
  parameter int n    = 32,
  parameter int frac = 16,
  parameter int iter = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic signed [n-1:0] x_i,
  input  logic signed [n-1:0] y_i,
  input  logic signed [n-1:0] z_i,
  output logic                busy_o,
  output logic                done_o,
  output logic signed [n-1:0] x_o,
  output logic signed [n-1:0] y_o,
  output logic signed [n-1:0] z_o,
  output logic        [3:0]   iter_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic        [3:0]   r_cnt;
  logic signed [n-1:0] r_x, r_y, r_z;
  logic signed [n-1:0] w_x_sh, w_y_sh, w_atan_cur;
  logic signed [n-1:0] w_x_nxt, w_y_nxt, w_z_nxt;
  logic        [n-1:0] w_atan [16];
  logic                w_load, w_step, w_last, w_neg;

  // atan(2^-i) built at elaboration in 2^-60 fixed point (pi/4 for i=0, Taylor series
  // otherwise), then rounded to the requested number of fractional bits.
  function automatic logic [n-1:0] atan_val(input int i);
    logic [63:0] acc;
    logic [63:0] term;
    int          sh;
    if (i == 0) begin
      acc = 64'h0C90FDAA22168C23;
    end else begin
      acc = '0;
      for (int k = 0; k < 32; k++) begin
        sh = i * (2 * k + 1);
        if (sh <= 60) begin
          term = (64'd1 << (60 - sh)) / 64'(2 * k + 1);
          if (k[0]) acc = acc - term;
          else      acc = acc + term;
        end
      end
    end
    acc = (acc + (64'd1 << (59 - frac))) >> (60 - frac);
    return acc[n-1:0];
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_lut
    localparam logic [n-1:0] ATAN = (g < iter) ? atan_val(g) : '0;
    assign w_atan[g] = ATAN;
  end

  shift_reg #(.WIDTH(n)) u_shift_x (.data_i(r_x), .addr_i(r_cnt), .data_o(w_x_sh));
  shift_reg #(.WIDTH(n)) u_shift_y (.data_i(r_y), .addr_i(r_cnt), .data_o(w_y_sh));

  assign w_atan_cur = w_atan[r_cnt];
  assign w_neg      = r_z[n-1];
  assign w_x_nxt    = w_neg ? r_x + w_y_sh     : r_x - w_y_sh;
  assign w_y_nxt    = w_neg ? r_y - w_x_sh     : r_y + w_x_sh;
  assign w_z_nxt    = w_neg ? r_z + w_atan_cur : r_z - w_atan_cur;
  assign w_last     = (r_cnt == 4'(iter - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // DONE accepts a new start directly so back-to-back operations lose no cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: if (start_i) begin
        w_load      = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
        if (start_i) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
      r_x   <= x_i;
      r_y   <= y_i;
      r_z   <= z_i;
    end else if (w_step) begin
      r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_z   <= w_z_nxt;
    end
  end

  assign busy_o = (r_state == RUN);
  assign done_o = (r_state == DONE);
  assign iter_o = busy_o ? r_cnt : 4'd0;
  assign x_o    = r_x;
  assign y_o    = r_y;
  assign z_o    = r_z;

endmodule

// File: tb/tb_cordic_seq.sv
// Bench for cordic_seq: directed vectors, random vectors against a real-arithmetic
// atan table, back-to-back operation, iteration index and reset abort.

module tb_cordic_seq;
  logic        clk_i = 1'b0;
  logic        rst_ni, start_i;
  logic [31:0] x_i, y_i, z_i, x_o, y_o, z_o;
  logic        busy_o, done_o;
  logic [3:0]  iter_o;

  int n_tests = 0;
  int n_fail  = 0;
  int lut [16];

  always #5 clk_i = ~clk_i;

  cordic_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .busy_o(busy_o), .done_o(done_o),
    .x_o(x_o), .y_o(y_o), .z_o(z_o), .iter_o(iter_o)
  );

  // Reference: 16 micro-rotations on 32-bit wrapping integers.
  function automatic void model(input int x0, input int y0, input int z0,
                                output int xe, output int ye, output int ze);
    int x, y, z, xs, ys;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < 16; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin x = x - ys; y = y + xs; z = z - lut[i]; end
      else        begin x = x + ys; y = y - xs; z = z + lut[i]; end
    end
    xe = x; ye = y; ze = z;
  endfunction

  // Call at a negedge; returns at the negedge where done_o is seen (or after 40 cycles).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        output int cyc);
    x_i = x; y_i = y; z_i = z; start_i = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk_i);
      start_i = 1'b0;
      cyc++;
    end while (!done_o && cyc < 40);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; x_i = '0; y_i = '0; z_i = '0;
    repeat (2) @(negedge clk_i);
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_o); end
    n_tests++; if (iter_o !== 4'd0) begin n_fail++; $display("FAIL reset_iter got %0d exp 0", iter_o); end
    n_tests++; if (x_o !== 32'd0) begin n_fail++; $display("FAIL reset_x got %h exp 0", x_o); end
    n_tests++; if (y_o !== 32'd0) begin n_fail++; $display("FAIL reset_y got %h exp 0", y_o); end
    n_tests++; if (z_o !== 32'd0) begin n_fail++; $display("FAIL reset_z got %h exp 0", z_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] vz [3];
    logic [31:0] ex [3];
    logic [31:0] ey [3];
    int cyc, xe, ye, ze, d;
    vz[0] = 32'h0;        ex[0] = 32'h00010000; ey[0] = 32'h0;
    vz[1] = 32'h0000C910; ex[1] = 32'h0000B505; ey[1] = 32'h0000B505;
    vz[2] = 32'hFFFF36F0; ex[2] = 32'h0000B505; ey[2] = 32'hFFFF4AFB;
    for (int v = 0; v < 3; v++) begin
      model(32'h00009B75, 0, vz[v], xe, ye, ze);
      run_op(32'h00009B75, 32'h0, vz[v], cyc);
      n_tests++; if (cyc != 17) begin n_fail++; $display("FAIL vec%0d_latency got %0d exp 17", v, cyc); end
      n_tests++; if (x_o !== xe || y_o !== ye || z_o !== ze) begin
        n_fail++; $display("FAIL vec%0d_model got %h %h %h exp %h %h %h", v, x_o, y_o, z_o, xe, ye, ze);
      end
      d = $signed(x_o) - $signed(ex[v]);
      n_tests++; if (d > 8 || d < -8) begin n_fail++; $display("FAIL vec%0d_x got %h exp %h+-8", v, x_o, ex[v]); end
      d = $signed(y_o) - $signed(ey[v]);
      n_tests++; if (d > 8 || d < -8) begin n_fail++; $display("FAIL vec%0d_y got %h exp %h+-8", v, y_o, ey[v]); end
      d = $signed(z_o);
      n_tests++; if (d > 8 || d < -8) begin n_fail++; $display("FAIL vec%0d_z got %h exp 0+-8", v, z_o); end
    end
  endtask

  task automatic test_iter_seq();
    logic [31:0] hx, hy, hz;
    x_i = 32'h00004000; y_i = 32'h00002000; z_i = 32'h00003000; start_i = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      n_tests++; if (iter_o !== 4'(j) || busy_o !== 1'b1) begin
        n_fail++; $display("FAIL iter_seq got %0d busy %b exp %0d busy 1", iter_o, busy_o, j);
      end
    end
    @(negedge clk_i);
    n_tests++; if (done_o !== 1'b1 || iter_o !== 4'd0) begin
      n_fail++; $display("FAIL iter_done got done %b iter %0d exp done 1 iter 0", done_o, iter_o);
    end
    hx = x_o; hy = y_o; hz = z_o;
    x_i = 32'h12345678; y_i = 32'h9ABCDEF0; z_i = 32'h0F0F0F0F;
    repeat (3) @(negedge clk_i);
    n_tests++; if (x_o !== hx || y_o !== hy || z_o !== hz || done_o !== 1'b0 || busy_o !== 1'b0 || iter_o !== 4'd0) begin
      n_fail++; $display("FAIL hold got %h %h %h d%b b%b i%0d exp %h %h %h d0 b0 i0", x_o, y_o, z_o, done_o, busy_o, iter_o, hx, hy, hz);
    end
  endtask

  task automatic test_random();
    int cyc, xe, ye, ze;
    logic [31:0] rx, ry, rz;
    for (int t = 0; t < 20; t++) begin
      rx = (t < 10) ? 32'($signed(16'($urandom))) : $urandom;
      ry = (t < 10) ? 32'($signed(16'($urandom))) : $urandom;
      rz = (t < 10) ? 32'($signed(18'($urandom))) : $urandom;
      model(rx, ry, rz, xe, ye, ze);
      run_op(rx, ry, rz, cyc);
      n_tests++; if (cyc != 17 || x_o !== xe || y_o !== ye || z_o !== ze) begin
        n_fail++; $display("FAIL random%0d got %h %h %h cyc %0d exp %h %h %h cyc 17", t, x_o, y_o, z_o, cyc, xe, ye, ze);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vx [5], vy [5], vz [5];
    int ex [5], ey [5], ez [5];
    int cur = 0, last = 0, ndone = 0, c = 0;
    for (int v = 0; v < 5; v++) begin
      vx[v] = 32'($signed(16'($urandom))); vy[v] = 32'($signed(16'($urandom)));
      vz[v] = 32'($signed(18'($urandom)));
      model(vx[v], vy[v], vz[v], ex[v], ey[v], ez[v]);
    end
    x_i = vx[0]; y_i = vy[0]; z_i = vz[0]; start_i = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        ndone++;
        n_tests++; if (k - last != 17 || busy_o !== 1'b0) begin
          n_fail++; $display("FAIL b2b_period got %0d busy %b exp 17 busy 0", k - last, busy_o);
        end
        n_tests++; if (x_o !== ex[cur] || y_o !== ey[cur] || z_o !== ez[cur]) begin
          n_fail++; $display("FAIL b2b_result%0d got %h %h %h exp %h %h %h", cur, x_o, y_o, z_o, ex[cur], ey[cur], ez[cur]);
        end
        last = k; cur++;
        x_i = vx[cur]; y_i = vy[cur]; z_i = vz[cur];
      end else begin
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1 at %0d", busy_o, k); end
        x_i = $urandom; y_i = $urandom; z_i = $urandom;
      end
    end
    start_i = 1'b0;
    n_tests++; if (ndone != 3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", ndone); end
    while (!done_o && c < 40) begin @(negedge clk_i); c++; end
    n_tests++; if (done_o !== 1'b1 || x_o !== ex[cur] || y_o !== ey[cur] || z_o !== ez[cur]) begin
      n_fail++; $display("FAIL b2b_tail got %h %h %h done %b exp %h %h %h", x_o, y_o, z_o, done_o, ex[cur], ey[cur], ez[cur]);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_abort();
    int c = 0, seen = 0, cyc, xe, ye, ze;
    x_i = 32'h00009B75; y_i = 32'h0; z_i = 32'h00004000; start_i = 1'b1;
    do begin @(negedge clk_i); start_i = 1'b0; c++; end while (iter_o !== 4'd7 && c < 30);
    n_tests++; if (iter_o !== 4'd7) begin n_fail++; $display("FAIL abort_reach got %0d exp 7", iter_o); end
    rst_ni = 1'b0;
    #1;
    n_tests++; if (busy_o !== 1'b0 || done_o !== 1'b0 || iter_o !== 4'd0 || x_o !== 32'd0 || y_o !== 32'd0 || z_o !== 32'd0) begin
      n_fail++; $display("FAIL abort_clear got b%b d%b i%0d %h %h %h exp all 0", busy_o, done_o, iter_o, x_o, y_o, z_o);
    end
    for (int k = 0; k < 20; k++) begin @(negedge clk_i); if (done_o) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_nodone got %0d pulses exp 0", seen); end
    rst_ni = 1'b1;
    model(32'h00009B75, 0, 0, xe, ye, ze);
    run_op(32'h00009B75, 32'h0, 32'h0, cyc);
    n_tests++; if (cyc != 17 || x_o !== xe || y_o !== ye || z_o !== ze) begin
      n_fail++; $display("FAIL abort_restart got %h %h %h cyc %0d exp %h %h %h cyc 17", x_o, y_o, z_o, cyc, xe, ye, ze);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++)
      lut[i] = $rtoi($floor($atan(2.0 ** (-i)) * 65536.0 + 0.5));
    test_reset();
    test_vectors();
    test_iter_seq();
    @(negedge clk_i);
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
